// File: rtl/kbd_pkg.sv
// Shared types, scan-code tables and usage-to-set-1 ROM for the HID-to-XT keyboard scheduler.
// KBD_EXT_PREFIX_EN widens the ROM to carry an extended-key flag in bit 8.
package kbd_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_MOD, S_BRK, S_MK, S_LOOK, S_PUSH
  } kbd_state_e;

  // key[0] is keycode1, key[2] is keycode3
  typedef struct packed {
    logic [7:0]      shift;
    logic [2:0][7:0] key;
  } hid_report_t;

  localparam logic [7:0] BREAK_BIT  = 8'h80;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] ROLLOVER   = 8'h01;

`ifdef KBD_EXT_PREFIX_EN
  localparam int unsigned ROM_W = 9;
`else
  localparam int unsigned ROM_W = 8;
`endif

  function automatic logic [7:0] mod_code(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h1D;
      3'd1:    c = 8'h2A;
      3'd2:    c = 8'h38;
      3'd3:    c = 8'h5B;
      3'd4:    c = 8'h1D;
      3'd5:    c = 8'h36;
      3'd6:    c = 8'h38;
      default: c = 8'h5C;
    endcase
    return c;
  endfunction

  // Right Ctrl, left GUI, right Alt and right GUI are extended keys
  function automatic logic mod_is_ext(input logic [2:0] idx);
    return (idx == 3'd3) || (idx == 3'd4) || (idx == 3'd6) || (idx == 3'd7);
  endfunction

  function automatic logic is_rollover(input hid_report_t r);
    return (r.key[0] == ROLLOVER) && (r.key[1] == ROLLOVER) && (r.key[2] == ROLLOVER);
  endfunction

  // Usage-to-set-1 ROM; bit 8 flags an extended key, 0 means unmapped
  function automatic logic [ROM_W-1:0] kbd_rom(input logic [7:0] usage);
    logic [8:0] c;
    case (usage)
      8'h04: c = 9'h01E; 8'h05: c = 9'h030; 8'h06: c = 9'h02E; 8'h07: c = 9'h020;
      8'h08: c = 9'h012; 8'h09: c = 9'h021; 8'h0A: c = 9'h022; 8'h0B: c = 9'h023;
      8'h0C: c = 9'h017; 8'h0D: c = 9'h024; 8'h0E: c = 9'h025; 8'h0F: c = 9'h026;
      8'h10: c = 9'h032; 8'h11: c = 9'h031; 8'h12: c = 9'h018; 8'h13: c = 9'h019;
      8'h14: c = 9'h010; 8'h15: c = 9'h013; 8'h16: c = 9'h01F; 8'h17: c = 9'h014;
      8'h18: c = 9'h016; 8'h19: c = 9'h02F; 8'h1A: c = 9'h011; 8'h1B: c = 9'h02D;
      8'h1C: c = 9'h015; 8'h1D: c = 9'h02C; 8'h1E: c = 9'h002; 8'h1F: c = 9'h003;
      8'h20: c = 9'h004; 8'h21: c = 9'h005; 8'h22: c = 9'h006; 8'h23: c = 9'h007;
      8'h24: c = 9'h008; 8'h25: c = 9'h009; 8'h26: c = 9'h00A; 8'h27: c = 9'h00B;
      8'h28: c = 9'h01C; 8'h29: c = 9'h001; 8'h2A: c = 9'h00E; 8'h2B: c = 9'h00F;
      8'h2C: c = 9'h039; 8'h4A: c = 9'h147; 8'h4C: c = 9'h153; 8'h4F: c = 9'h14D;
      8'h50: c = 9'h14B; 8'h51: c = 9'h150; 8'h52: c = 9'h148;
      default: c = 9'h000;
    endcase
    return ROM_W'(c);
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scan-code FIFO with flush; a push on a full FIFO is accepted when a pop coincides.
module kbd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty && !i_flush;
  assign w_wr    = i_push && (!o_full || w_rd) && !i_flush;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_sched.sv
// Diffs HID keyboard reports into XT set-1 make/break bytes and serves them on ports 60h/61h/64h with IRQ1.
// Define KBD_EXT_PREFIX_EN to emit the E0h prefix for extended keys.
module kbd_event_sched
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned HOLDOFF    = 256,
  parameter logic [11:0] PORT_DATA  = 12'h060,
  parameter logic [11:0] PORT_CTRL  = 12'h061,
  parameter logic [11:0] PORT_STAT  = 12'h064
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  shift,
  input  logic [7:0]  keycode1,
  input  logic [7:0]  keycode2,
  input  logic [7:0]  keycode3,
  input  logic [11:0] port,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        cpu_iordin,
  output logic        cpu_iordout,
  input  logic        cpu_iowrin,
  output logic        cpu_iowrout,
  output logic        irq1,
  output logic        overflow
);

  localparam int unsigned HOLD_W  = $clog2(HOLDOFF + 1);
  localparam int unsigned STALL_W = 10;

  hid_report_t      w_report, r_sync1, r_sync2, r_old, r_new;
  kbd_state_e       r_state, r_ret, w_adv_state;
  logic [2:0]       r_idx, r_ret_idx, w_adv_idx;
  logic [7:0]       r_usage, r_byte, w_push_byte, w_mod_code, w_old_key, w_new_key, w_fifo_head;
  logic [ROM_W-1:0] w_rom;
  logic [STALL_W-1:0] r_stall;
  logic             r_brk, r_pfx, r_change_q, w_change, w_old_in_new, w_new_in_old;
  logic             r_iordout, r_iowrout, r_sel_data, r_sel_ctrl, r_sel_stat;
  logic             w_rd_data, w_rd_stat, w_rd_ctrl, w_wr_ctrl, w_flush, w_clr;
  logic             r_obf, r_irq, r_ovf, w_load, w_push_ok, w_drop, w_fifo_full, w_fifo_empty;
  logic [7:0]       r_obf_data, r_dout;
  logic [HOLD_W-1:0] r_hold;
  logic             w_unused;

  assign w_report = {shift, keycode3, keycode2, keycode1};
  assign w_change = (r_sync2 != r_old) && !is_rollover(r_sync2);

  assign w_mod_code   = mod_code(r_idx);
  assign w_old_key    = r_old.key[r_idx[1:0]];
  assign w_new_key    = r_new.key[r_idx[1:0]];
  assign w_old_in_new = (w_old_key == r_new.key[0]) || (w_old_key == r_new.key[1]) ||
                        (w_old_key == r_new.key[2]);
  assign w_new_in_old = (w_new_key == r_old.key[0]) || (w_new_key == r_old.key[1]) ||
                        (w_new_key == r_old.key[2]);
  assign w_rom        = kbd_rom(r_usage);
  assign w_push_byte  = r_pfx ? EXT_PREFIX : r_byte;

  // CPU side decode: address compare is registered one cycle ahead of the toggle
  assign w_rd_data = (cpu_iordin ^ r_iordout) && r_sel_data;
  assign w_rd_stat = (cpu_iordin ^ r_iordout) && r_sel_stat;
  assign w_rd_ctrl = (cpu_iordin ^ r_iordout) && r_sel_ctrl;
  assign w_wr_ctrl = (cpu_iowrin ^ r_iowrout) && r_sel_ctrl;
  assign w_flush   = w_wr_ctrl && din[6];
  assign w_clr     = w_wr_ctrl && din[7];
  assign w_unused  = &{1'b0, din[5:0], w_mod_code[7]};

  assign w_load    = !r_obf && !w_fifo_empty && (r_hold == '0) && !w_rd_data && !w_flush;
  assign w_push_ok = (r_state == S_PUSH) && (!w_fifo_full || w_load);
  assign w_drop    = (r_state == S_PUSH) && !w_push_ok && (r_stall == '1);

  // Where iteration goes after the current slot/bit
  always_comb begin
    w_adv_state = r_state;
    w_adv_idx   = r_idx + 3'd1;
    case (r_state)
      S_MOD: if (r_idx == 3'd7) begin w_adv_state = S_BRK;  w_adv_idx = '0; end
      S_BRK: if (r_idx == 3'd2) begin w_adv_state = S_MK;   w_adv_idx = '0; end
      S_MK:  if (r_idx == 3'd2) begin w_adv_state = S_IDLE; w_adv_idx = '0; end
      default: ;
    endcase
  end

  kbd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push_ok),
    .i_data  (w_push_byte),
    .i_pop   (w_load),
    .i_flush (w_flush),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Report sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_idx      <= '0;
      r_ret_idx  <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_old      <= '0;
      r_new      <= '0;
      r_change_q <= 1'b0;
      r_usage    <= '0;
      r_brk      <= 1'b0;
      r_byte     <= '0;
      r_pfx      <= 1'b0;
      r_stall    <= '0;
    end else begin
      r_sync1    <= w_report;
      r_sync2    <= r_sync1;
      r_change_q <= (r_state == S_IDLE) && w_change;
      case (r_state)
        S_IDLE: if (w_change && r_change_q) r_state <= S_LATCH;
        S_LATCH: begin
          if (is_rollover(r_sync2)) begin
            r_state <= S_IDLE;
          end else begin
            r_new   <= r_sync2;
            r_idx   <= '0;
            r_state <= S_MOD;
          end
        end
        S_MOD: begin
          if (r_old.shift[r_idx] != r_new.shift[r_idx]) begin
            r_byte    <= {1'b0, w_mod_code[6:0]} | (r_new.shift[r_idx] ? 8'h00 : BREAK_BIT);
`ifdef KBD_EXT_PREFIX_EN
            r_pfx     <= mod_is_ext(r_idx);
`endif
            r_stall   <= '0;
            r_ret     <= w_adv_state;
            r_ret_idx <= w_adv_idx;
            r_state   <= S_PUSH;
          end else begin
            r_state <= w_adv_state;
            r_idx   <= w_adv_idx;
          end
        end
        S_BRK, S_MK: begin
          if ((r_state == S_BRK) ? (w_old_key != '0 && !w_old_in_new)
                                 : (w_new_key != '0 && !w_new_in_old)) begin
            r_usage   <= (r_state == S_BRK) ? w_old_key : w_new_key;
            r_brk     <= (r_state == S_BRK);
            r_ret     <= w_adv_state;
            r_ret_idx <= w_adv_idx;
            r_state   <= S_LOOK;
          end else begin
            r_state <= w_adv_state;
            r_idx   <= w_adv_idx;
            if (w_adv_state == S_IDLE) r_old <= r_new;
          end
        end
        S_LOOK: begin
          if (w_rom == '0) begin
            r_state <= r_ret;
            r_idx   <= r_ret_idx;
            if (r_ret == S_IDLE) r_old <= r_new;
          end else begin
            r_byte  <= {1'b0, w_rom[6:0]} | (r_brk ? BREAK_BIT : 8'h00);
`ifdef KBD_EXT_PREFIX_EN
            r_pfx   <= w_rom[8];
`endif
            r_stall <= '0;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          // Byte leaves either into the FIFO or, after the stall budget, is dropped
          if (w_push_ok || w_drop) begin
            r_stall <= '0;
            if (r_pfx) begin
              r_pfx <= 1'b0;
            end else begin
              r_state <= r_ret;
              r_idx   <= r_ret_idx;
              if (r_ret == S_IDLE) r_old <= r_new;
            end
          end else begin
            r_stall <= r_stall + STALL_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CPU port handshake, output buffer and IRQ1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iordout  <= 1'b0;
      r_iowrout  <= 1'b0;
      r_sel_data <= 1'b0;
      r_sel_ctrl <= 1'b0;
      r_sel_stat <= 1'b0;
      r_obf      <= 1'b0;
      r_obf_data <= '0;
      r_irq      <= 1'b0;
      r_ovf      <= 1'b0;
      r_dout     <= '0;
      r_hold     <= '0;
    end else begin
      r_iordout  <= cpu_iordin;
      r_iowrout  <= cpu_iowrin;
      r_sel_data <= (port == PORT_DATA);
      r_sel_ctrl <= (port == PORT_CTRL);
      r_sel_stat <= (port == PORT_STAT);
      if (r_hold != '0) r_hold <= r_hold - HOLD_W'(1);
      if (w_load) begin
        r_obf_data <= w_fifo_head;
        r_obf      <= 1'b1;
        r_irq      <= 1'b1;
      end
      if (w_rd_data) begin
        r_dout <= r_obf_data;
        r_obf  <= 1'b0;
        r_irq  <= 1'b0;
        r_hold <= HOLD_W'(HOLDOFF);
      end
      if (w_rd_stat) r_dout <= {6'b0, w_fifo_full, r_obf};
      if (w_rd_ctrl) r_dout <= {r_ovf, 7'b0};
      if (w_clr) begin
        r_irq <= 1'b0;
        r_ovf <= 1'b0;
      end
      if (w_flush) begin
        r_obf <= 1'b0;
        r_irq <= 1'b0;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign dout        = r_dout;
  assign irq1        = r_irq;
  assign overflow    = r_ovf;
  assign cpu_iordout = r_iordout;
  assign cpu_iowrout = r_iowrout;

endmodule

// File: tb/tb_kbd_event_sched.sv
// Directed bench for kbd_event_sched: key diffing, CPU ports, holdoff, overflow, flush and reset.
module tb_kbd_event_sched;
  import kbd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  shift, keycode1, keycode2, keycode3;
  logic [11:0] port;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        cpu_iordin, cpu_iordout, cpu_iowrin, cpu_iowrout;
  logic        irq1, overflow;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [11:0] P_DATA = 12'h060;
  localparam logic [11:0] P_CTRL = 12'h061;
  localparam logic [11:0] P_STAT = 12'h064;

  kbd_event_sched dut (
    .clk(clk), .reset_n(reset_n), .shift(shift), .keycode1(keycode1),
    .keycode2(keycode2), .keycode3(keycode3), .port(port), .din(din), .dout(dout),
    .cpu_iordin(cpu_iordin), .cpu_iordout(cpu_iordout), .cpu_iowrin(cpu_iowrin),
    .cpu_iowrout(cpu_iowrout), .irq1(irq1), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cpu_read(input logic [11:0] a, output logic [7:0] d);
    @(negedge clk); port = a;
    @(negedge clk); cpu_iordin = ~cpu_iordin;
    @(negedge clk); d = dout;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] v);
    @(negedge clk); port = a; din = v;
    @(negedge clk); cpu_iowrin = ~cpu_iowrin;
    @(negedge clk);
  endtask

  task automatic set_report(input logic [7:0] s, input logic [7:0] k1,
                            input logic [7:0] k2, input logic [7:0] k3);
    @(negedge clk); shift = s; keycode1 = k1; keycode2 = k2; keycode3 = k3;
  endtask

  // Returns cycles until irq1 was seen high, or -1 on timeout
  task automatic wait_irq(input int max, output int waited);
    waited = -1;
    for (int i = 0; i < max; i++) begin
      if (irq1) begin waited = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic read_byte(input string name, input logic [7:0] want);
    int w;
    logic [7:0] d;
    wait_irq(700, w);
    n_total++;
    if (w < 0) begin n_bad++; $display("FAIL %s_irq got=timeout want=irq1 high", name); end
    cpu_read(P_DATA, d);
    n_total++;
    if (d !== want) begin n_bad++; $display("FAIL %s got=%h want=%h", name, d, want); end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset_n = 1'b0; shift = '0; keycode1 = '0; keycode2 = '0; keycode3 = '0;
    port = '0; din = '0; cpu_iordin = 1'b0; cpu_iowrin = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({dout, irq1, overflow, cpu_iordout, cpu_iowrout} !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=000", {dout, irq1, overflow, cpu_iordout, cpu_iowrout});
    end
    reset_n = 1'b1;
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL reset_status got=%h want=00", d); end
  endtask

  task automatic test_handshake;
    @(negedge clk); port = 12'h070; cpu_iowrin = ~cpu_iowrin;
    @(negedge clk);
    n_total++;
    if (cpu_iowrout !== cpu_iowrin) begin n_bad++; $display("FAIL wr_ack got=%b want=%b", cpu_iowrout, cpu_iowrin); end
    cpu_iordin = ~cpu_iordin;
    @(negedge clk);
    n_total++;
    if (cpu_iordout !== cpu_iordin) begin n_bad++; $display("FAIL rd_ack got=%b want=%b", cpu_iordout, cpu_iordin); end
    n_total++;
    if (dout !== 8'h00) begin n_bad++; $display("FAIL unmapped_read got=%h want=00", dout); end
  endtask

  task automatic test_press_release;
    int w;
    logic [7:0] d;
    set_report(8'h00, 8'h04, 8'h00, 8'h00);
    wait_irq(100, w);
    n_total++;
    if (w < 0) begin n_bad++; $display("FAIL press_irq got=timeout want=irq1 high"); end
    set_report(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (50) @(negedge clk);
    cpu_read(P_DATA, d);
    n_total++;
    if (d !== 8'h1E) begin n_bad++; $display("FAIL press_make got=%h want=1e", d); end
    n_total++;
    if (irq1 !== 1'b0) begin n_bad++; $display("FAIL press_irq_clr got=%b want=0", irq1); end
    wait_irq(600, w);
    n_total++;
    if (w != 257) begin n_bad++; $display("FAIL holdoff_cycles got=%0d want=257", w); end
    cpu_read(P_DATA, d);
    n_total++;
    if (d !== 8'h9E) begin n_bad++; $display("FAIL release_break got=%h want=9e", d); end
    repeat (300) @(negedge clk);
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00 || irq1 !== 1'b0) begin n_bad++; $display("FAIL press_drained got=%h/%b want=00/0", d, irq1); end
  endtask

  task automatic test_mod_key;
    set_report(8'h02, 8'h04, 8'h00, 8'h00);
    read_byte("mod_make", 8'h2A);
    read_byte("key_make", 8'h1E);
    set_report(8'h00, 8'h00, 8'h00, 8'h00);
    read_byte("mod_break", 8'hAA);
    read_byte("key_break", 8'h9E);
  endtask

  task automatic test_rollover;
    logic [7:0] d;
    set_report(8'h00, 8'h04, 8'h00, 8'h00);
    read_byte("roll_pre", 8'h1E);
    set_report(8'h00, 8'h01, 8'h01, 8'h01);
    repeat (400) @(negedge clk);
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL rollover_silent got=%h want=00", d); end
    set_report(8'h00, 8'h04, 8'h00, 8'h00);
    repeat (400) @(negedge clk);
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL rollover_snapshot got=%h want=00", d); end
    set_report(8'h00, 8'h00, 8'h00, 8'h00);
    read_byte("roll_post", 8'h9E);
  endtask

  task automatic test_status_flush;
    int w;
    logic [7:0] d;
    repeat (300) @(negedge clk);
    set_report(8'h00, 8'h04, 8'h00, 8'h00);
    wait_irq(100, w);
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h01) begin n_bad++; $display("FAIL stat_pending got=%h want=01", d); end
    cpu_read(P_CTRL, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL ctrl_no_ovf got=%h want=00", d); end
    cpu_write(P_CTRL, 8'h40);
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00 || irq1 !== 1'b0) begin n_bad++; $display("FAIL flush got=%h/%b want=00/0", d, irq1); end
    set_report(8'h00, 8'h00, 8'h00, 8'h00);
    read_byte("flush_after", 8'h9E);
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      set_report(8'h00, (i % 2 == 0) ? 8'h04 : 8'h00, 8'h00, 8'h00);
      repeat (1200) @(negedge clk);
      if (i == 16) begin
        n_total++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
        cpu_read(P_STAT, d);
        n_total++;
        if (d !== 8'h03) begin n_bad++; $display("FAIL ovf_full_stat got=%h want=03", d); end
      end
    end
    n_total++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    cpu_read(P_CTRL, d);
    n_total++;
    if (d !== 8'h80) begin n_bad++; $display("FAIL ovf_ctrl got=%h want=80", d); end
    cpu_write(P_CTRL, 8'h80);
    n_total++;
    if (overflow !== 1'b0 || irq1 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b/%b want=0/0", overflow, irq1); end
    cpu_read(P_CTRL, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL ovf_ctrl_clr got=%h want=00", d); end
    cpu_read(P_DATA, d);
    n_total++;
    if (d !== 8'h1E) begin n_bad++; $display("FAIL ovf_obf_kept got=%h want=1e", d); end
    cpu_write(P_CTRL, 8'h40);
    repeat (300) @(negedge clk);
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL ovf_flushed got=%h want=00", d); end
  endtask

  task automatic test_reset_mid;
    int w;
    logic [7:0] d;
    set_report(8'h00, 8'h04, 8'h00, 8'h00);
    w = -1;
    for (int i = 0; i < 100; i++) begin
      if (dut.r_state == S_MK) begin w = i; break; end
      @(negedge clk);
    end
    n_total++;
    if (w < 0) begin n_bad++; $display("FAIL reach_mk got=timeout want=state MK"); end
    reset_n = 1'b0; cpu_iordin = 1'b0; cpu_iowrin = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dout, irq1, overflow, cpu_iordout, cpu_iowrout} !== 12'h000) begin
      n_bad++; $display("FAIL midreset_outputs got=%h want=000", {dout, irq1, overflow, cpu_iordout, cpu_iowrout});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL midreset_empty got=%h want=00", d); end
    read_byte("midreset_make", 8'h1E);
    repeat (400) @(negedge clk);
    cpu_read(P_STAT, d);
    n_total++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL midreset_no_break got=%h want=00", d); end
  endtask

  initial begin
    test_reset;
    test_handshake;
    test_press_release;
    test_mod_key;
    test_rollover;
    test_status_flush;
    test_overflow;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/kbd_event_sched.md
Name: kbd_event_sched

Overview:
- Sequences the USB low-speed HID keyboard report (modifier byte plus three key slots) into an XT scan-code byte stream for the 286 core.
- On each report change, the block diffs the new report against the last processed one, emits break codes before make codes into a FIFO, and serves them through I/O ports 60h/61h/64h with IRQ1.
- Sits between USB_LS_HID and the CPU I/O bus, beside the existing port decode.

Parameters:
- FIFO_DEPTH, 16: scan-code FIFO entries; must be a power of two.
- HOLDOFF, 256: clk cycles after a port-60h read before the next byte is loaded into the output buffer.
- PORT_DATA, 12'h060: data port.
- PORT_CTRL, 12'h061: control port.
- PORT_STAT, 12'h064: status port.

Ports:
- clk  in  1  system clock; every register is clocked on the posedge.
- reset_n  in  1  asynchronous, active-low reset.
- shift  in  8  HID modifier byte.
- keycode1  in  8  HID key slot 1 usage code.
- keycode2  in  8  HID key slot 2 usage code.
- keycode3  in  8  HID key slot 3 usage code.
- port  in  12  CPU I/O address.
- din  in  8  CPU write data.
- dout  out  8  CPU read data.
- cpu_iordin  in  1  read request toggle.
- cpu_iordout  out  1  read acknowledge toggle.
- cpu_iowrin  in  1  write request toggle.
- cpu_iowrout  out  1  write acknowledge toggle.
- irq1  out  1  keyboard interrupt, level.
- overflow  out  1  sticky flag: an event was dropped on a full FIFO.

Behaviour:
- Reset: all outputs are 0, including dout, irq1, overflow, cpu_iordout and cpu_iowrout. The FIFO is empty, the snapshot registers are 0, and the FSM is in IDLE.
- CPU handshake:
  - iord = cpu_iordin ^ cpu_iordout; iowr = cpu_iowrin ^ cpu_iowrout.
  - cpu_iordout follows cpu_iordin with one clk of delay; cpu_iowrout follows cpu_iowrin the same way.
  - Port compare is registered, so decode lags the address by one cycle.
- Change detect:
  - Inputs are double-registered.
  - IDLE leaves to LATCH when the synchronised {shift, keycode1..3} differs from the snapshot for 2 consecutive cycles.
  - A report with all three slots equal to 8'h01 (rollover error) is ignored, and the snapshot is kept.
- FSM states: IDLE, LATCH, MOD, BRK, MK, LOOK, PUSH.
- LATCH: captures the new report into a "new" register set. The old snapshot is kept.
- MOD: iterates bits i = 0..7. For each bit where old differs from new, emits the modifier scan code from the package table; bit 7 of the code is set when the modifier is released.
- BRK: iterates old slots 1..3. A non-zero usage that is absent from all three new slots is sent to LOOK with break = 1.
- MK: iterates new slots 1..3. A non-zero usage that is absent from all three old slots is sent to LOOK with break = 0.
- LOOK:
  - One-cycle ROM read (usage to set-1 code).
  - A ROM result of 0 means the key is skipped and no push occurs.
- PUSH:
  - Writes {break, code[6:0]} into the FIFO.
  - If the FIFO is full, the FSM stalls in PUSH up to 1024 cycles, then drops the byte and sets overflow.
- After MK slot 3: snapshot <= new, then return to IDLE.
- Reports that change mid-sequence are handled on the next pass; intermediate states may be skipped.
- Output buffer (OBF): when OBF = 0, the FIFO is non-empty and the holdoff counter is 0:
  - the FIFO head is popped into obf_data;
  - OBF <= 1 and irq1 <= 1 on the same cycle.
- CPU reads:
  - Read of PORT_DATA: dout = obf_data; OBF, irq1 <= 0; holdoff counter <= HOLDOFF.
  - Read of PORT_STAT: dout = {6'b0, fifo_full, OBF}.
  - Read of PORT_CTRL: dout = {overflow, 7'b0}.
- CPU writes:
  - Write of PORT_CTRL with din[7] = 1 clears irq1 and overflow. OBF is kept.
  - Write of PORT_CTRL with din[6] = 1 flushes the FIFO and clears OBF.
- Simultaneous events:
  - A FIFO push and pop in the same cycle are both honoured.
  - A CPU flush and an FSM push in the same cycle: the flush wins and the pushed byte is discarded.
- Reset mid-sequence: everything returns to the reset state. A key still held afterwards produces a make code only.

Optional Feature:
- Macro: KBD_EXT_PREFIX_EN.
- When defined: right Ctrl, right Alt, right GUI and left GUI, plus any ROM entry flagged extended (ROM bit 8), push 8'hE0 before the code. The FIFO-full stall applies to each byte.
- When undefined: no prefix is emitted; the ROM is 8 bits wide and right-hand modifiers map to their left-hand codes.

Decomposition:
- Package kbd_pkg:
  - FSM state enum;
  - modifier-to-scan-code table MOD_CODE[0:7] = 1D, 2A, 38, 5B, 1D, 36, 38, 5C;
  - BREAK_BIT = 8'h80;
  - EXT_PREFIX = 8'hE0;
  - ROLLOVER = 8'h01.
- Sub-module kbd_fifo: synchronous FIFO with full, empty, push, pop and flush signals.
- The usage-to-scan-code ROM is the existing keyboard ROM.

Test Plan:
- Key press and release: keycode1 = 04h, then 00h → FIFO receives 1Eh then 9Eh. Reading 60h twice returns 1Eh and 9Eh. irq1 rises once per byte.
- Modifier plus key in one report: shift = 02h with keycode1 = 04h → order is 2Ah, 1Eh. Releasing both in one report → AAh, 9Eh (break codes precede make codes within one report).
- Rollover: report {00, 01, 01, 01} → no bytes produced and the snapshot is unchanged.
- Overflow: 20 keys toggled without any CPU reads → 16 bytes held, overflow = 1 after the stall timeout, 61h reads 80h. Writing 61h = 80h clears overflow.
- Status and flush:
  - 64h reads 01h while a byte is pending.
  - Writing 61h = 40h → 64h reads 00h and irq1 = 0.
- Reset asserted in MK → all outputs are 0 and the FIFO is empty. With keycode1 = 04h still held, only 1Eh follows (no 9Eh).
